// File: rtl/wallace_pipe_pkg.sv
// Shared types, defaults and helpers for the Wallace-tree pipeline stage.
package wallace_pipe_pkg;

    // Stage fill level, derived from the main/skid valid bits.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    localparam int unsigned WP_ROW_W = 65;
    localparam int unsigned WP_CNT_W = 16;

    // Number of entries held, given the two valid bits.
    function automatic logic [1:0] occupancy_of(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/wallace_pipe_reg.sv
// Enabled data register with synchronous active-low clear.
module wallace_pipe_reg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    // Load on enable; reset clears the contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/wallace_pipe_stage.sv
// Elastic pipeline register between Wallace-tree reduction levels: main register M drives
// the output, skid register S absorbs one extra beat under backpressure.
// Optional feature: define WALLACE_PIPE_PARITY_EN to store per-row even parity beside M/S
// and raise a sticky parity_err_o when the emitted rows no longer match it.
module wallace_pipe_stage
    import wallace_pipe_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 2,
    parameter int unsigned NUM_ROWS  = 10,
    parameter int unsigned ROW_W     = WP_ROW_W,
    parameter int unsigned CNT_W     = WP_CNT_W
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [NUM_BANKS*NUM_ROWS*ROW_W-1:0] in_data_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [NUM_BANKS*NUM_ROWS*ROW_W-1:0] out_data_o,
    output logic [1:0]                        occupancy_o,
    output logic [CNT_W-1:0]                  stall_cnt_o,
    output logic                              parity_err_o
);

    localparam int unsigned NumRowsTot = NUM_BANKS * NUM_ROWS;
    localparam int unsigned DataW      = NumRowsTot * ROW_W;
`ifdef WALLACE_PIPE_PARITY_EN
    localparam int unsigned RegW = DataW + NumRowsTot;
`else
    localparam int unsigned RegW = DataW;
`endif

    logic            m_valid_q, m_valid_d;
    logic            s_valid_q, s_valid_d;
    logic            m_en, s_en, m_from_s;
    logic            accept, emit;
    stage_state_e    state;
    logic [RegW-1:0] cap_d;
    logic [RegW-1:0] m_d;
    logic [RegW-1:0] m_q;
    logic [RegW-1:0] s_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign state = s_valid_q ? FULL : (m_valid_q ? ONE : EMPTY);

    assign in_ready_o  = !s_valid_q;
    assign out_valid_o = m_valid_q;
    assign occupancy_o = occupancy_of(m_valid_q, s_valid_q);
    assign out_data_o  = m_q[DataW-1:0];
    assign stall_cnt_o = stall_cnt_q;

    assign accept = in_valid_i & in_ready_o;
    assign emit   = out_valid_o & out_ready_i;

`ifdef WALLACE_PIPE_PARITY_EN
    function automatic logic [NumRowsTot-1:0] row_parity(input logic [DataW-1:0] d);
        logic [NumRowsTot-1:0] p;
        p = '0;
        for (int unsigned r = 0; r < NumRowsTot; r++) begin
            p[r] = ^d[r*ROW_W +: ROW_W];
        end
        return p;
    endfunction

    assign cap_d = {row_parity(in_data_i), in_data_i};
`else
    assign cap_d = in_data_i;
`endif

    // Next-state for the valid bits and load enables of M and S.
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_en      = 1'b0;
        s_en      = 1'b0;
        m_from_s  = 1'b0;
        if (flush_i) begin
            // Drop everything held; the data registers keep their stale contents.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        m_valid_d = 1'b1;
                        m_en      = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        m_en = 1'b1;
                    end else if (accept) begin
                        s_valid_d = 1'b1;
                        s_en      = 1'b1;
                    end else if (emit) begin
                        m_valid_d = 1'b0;
                    end
                end
                FULL: begin
                    if (emit) begin
                        s_valid_d = 1'b0;
                        m_en      = 1'b1;
                        m_from_s  = 1'b1;
                    end
                end
                default: begin
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end
    end

    assign m_d = m_from_s ? s_q : cap_d;

    // Valid bits; reset dominates flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    wallace_pipe_reg #(
        .Width (RegW)
    ) u_m_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (m_en),
        .d_i  (m_d),
        .q_o  (m_q)
    );

    wallace_pipe_reg #(
        .Width (RegW)
    ) u_s_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (s_en),
        .d_i  (cap_d),
        .q_o  (s_q)
    );

    // Saturating stall counter: one count per cycle the output is held back.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

`ifdef WALLACE_PIPE_PARITY_EN
    logic parity_err_q;
    logic par_mismatch;

    assign par_mismatch = |(row_parity(m_q[DataW-1:0]) ^ m_q[RegW-1:DataW]);

    // Sticky error: set on any mismatch while M is valid, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_err_q <= 1'b0;
        end else if (m_valid_q && par_mismatch) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wallace_pipe_stage.sv
// Self-checking bench for wallace_pipe_stage against a queue-based reference model.
module tb_wallace_pipe_stage;

    localparam int unsigned DW = 2 * 10 * 65;
    typedef logic [DW-1:0] beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    beat_t       in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    beat_t       out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;
    logic        parity_err;

    // Small instance for counter saturation.
    logic        s_flush = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [7:0]  s_in_data = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [7:0]  s_out_data;
    logic [1:0]  s_occupancy;
    logic [3:0]  s_stall_cnt;
    logic        s_parity_err;

    int checks = 0;
    int errors = 0;

    // Reference model: beats held in the stage, oldest first.
    beat_t       held[$];
    logic [15:0] m_stall = '0;
    beat_t       obs[$];

    always #5 clk = ~clk;

    wallace_pipe_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .occupancy_o  (occupancy),
        .stall_cnt_o  (stall_cnt),
        .parity_err_o (parity_err)
    );

    wallace_pipe_stage #(
        .NUM_BANKS (1),
        .NUM_ROWS  (1),
        .ROW_W     (8),
        .CNT_W     (4)
    ) u_sat (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (s_flush),
        .in_valid_i   (s_in_valid),
        .in_ready_o   (s_in_ready),
        .in_data_i    (s_in_data),
        .out_valid_o  (s_out_valid),
        .out_ready_i  (s_out_ready),
        .out_data_o   (s_out_data),
        .occupancy_o  (s_occupancy),
        .stall_cnt_o  (s_stall_cnt),
        .parity_err_o (s_parity_err)
    );

    function automatic beat_t rand_beat();
        beat_t b = '0;
        for (int i = 0; i < (DW + 31) / 32; i++) begin
            b = {b[DW-33:0], 32'($urandom)};
        end
        return b;
    endfunction

    function automatic beat_t row_beat(input int k);
        logic [64:0] row;
        row = 65'h1_0000_0000_0000_0001 + 65'(k);
        return {20{row}};
    endfunction

    // Drive one cycle of inputs, advance the model, and land #1 after the edge.
    task automatic cycle(input logic v, input beat_t d, input logic r, input logic f,
                         input logic rs);
        logic em, ac;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        rst       = rs;
        if (rs && !f && out_valid && r) obs.push_back(out_data);
        if (!rs) begin
            held.delete();
            m_stall = '0;
        end else begin
            if (held.size() > 0 && !r && m_stall != 16'hFFFF) m_stall++;
            em = (held.size() > 0) && r;
            ac = v && (held.size() < 2);
            if (f) begin
                held.delete();
            end else begin
                if (em) void'(held.pop_front());
                if (ac) held.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, rand_beat(), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, rand_beat(), 1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            errors++; $display("FAIL reset_out_data got %0h want 0", out_data);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        checks++;
        if (occupancy !== 2'd0) begin
            errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy);
        end
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt);
        end
        checks++;
        if (parity_err !== 1'b0) begin
            errors++; $display("FAIL reset_parity_err got %0b want 0", parity_err);
        end
    endtask

    task automatic test_streaming();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, row_beat(k), 1'b1, 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b1 || out_data !== row_beat(k)) begin
                errors++;
                $display("FAIL stream_beat%0d got v=%0b d=%0h want v=1 d=%0h", k, out_valid,
                         out_data[64:0], row_beat(k) >> (DW - 65));
            end
            checks++;
            if (occupancy !== 2'd1 || stall_cnt !== 16'd0) begin
                errors++;
                $display("FAIL stream_occ%0d got occ=%0d stall=%0d want occ=1 stall=0", k,
                         occupancy, stall_cnt);
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_drain got v=%0b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        beat_t b[3];
        for (int i = 0; i < 3; i++) b[i] = rand_beat();
        obs.delete();
        cycle(1'b1, b[0], 1'b0, 1'b0, 1'b1);
        checks++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_first got occ=%0d rdy=%0b want 1/1", occupancy, in_ready);
        end
        cycle(1'b1, b[1], 1'b0, 1'b0, 1'b1);
        checks++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full got occ=%0d rdy=%0b want 2/0", occupancy, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, b[2], 1'b0, 1'b0, 1'b1);
            checks++;
            if (stall_cnt !== m_stall || occupancy !== 2'd2 || out_data !== b[0]) begin
                errors++;
                $display("FAIL bp_stall%0d got stall=%0d occ=%0d want stall=%0d occ=2", i,
                         stall_cnt, occupancy, m_stall);
            end
        end
        // Keep offering b2 until the model says it was taken, then drain.
        for (int i = 0; i < 6; i++) begin
            if (held.size() == 2 || (i == 1)) cycle(1'b1, b[2], 1'b1, 1'b0, 1'b1);
            else cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (occupancy !== 2'(held.size()) || out_valid !== (held.size() > 0)) begin
                errors++;
                $display("FAIL bp_drain%0d got occ=%0d want %0d", i, occupancy, held.size());
            end
        end
        checks++;
        if (obs.size() != 3) begin
            errors++; $display("FAIL bp_count got %0d beats want 3", obs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== b[i]) begin
                    errors++; $display("FAIL bp_order%0d got %0h want %0h", i, obs[i][31:0],
                                       b[i][31:0]);
                end
            end
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, rand_beat(), 1'b0, 1'b0, 1'b1);
        obs.delete();
        cycle(1'b1, rand_beat(), 1'b0, 1'b1, 1'b1);
        checks++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got occ=%0d v=%0b rdy=%0b want 0/0/1", occupancy,
                     out_valid, in_ready);
        end
        checks++;
        if (stall_cnt !== m_stall) begin
            errors++; $display("FAIL flush_stall got %0d want %0d", stall_cnt, m_stall);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (obs.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_ghost got %0d beats want 0", obs.size());
        end
    endtask

    task automatic test_back_to_back();
        logic v, r, f, rs;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom % 4) != 0;
            r  = ($urandom % 3) != 0;
            f  = ($urandom % 40) == 0;
            rs = ($urandom % 97) != 0;
            cycle(v, rand_beat(), r, f, rs);
            checks++;
            if (out_valid !== (held.size() > 0) || in_ready !== (held.size() < 2) ||
                occupancy !== 2'(held.size()) || stall_cnt !== m_stall ||
                parity_err !== 1'b0 || (held.size() > 0 && out_data !== held[0])) begin
                errors++;
                $display("FAIL rand%0d got v=%0b rdy=%0b occ=%0d stall=%0d want occ=%0d stall=%0d",
                         i, out_valid, in_ready, occupancy, stall_cnt, held.size(), m_stall);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        s_in_valid  = 1'b1;
        s_in_data   = 8'hA5;
        s_out_ready = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        s_in_valid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
            exp_cnt = (n > 15) ? 15 : n;
            checks++;
            if (s_stall_cnt !== 4'(exp_cnt) || s_out_data !== 8'hA5 || s_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL sat%0d got cnt=%0d d=%0h want cnt=%0d d=a5", n, s_stall_cnt,
                         s_out_data, exp_cnt);
            end
        end
        s_out_ready = 1'b1;
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_parity();
        beat_t b;
        b = rand_beat();
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, b, 1'b0, 1'b0, 1'b1);
`ifdef WALLACE_PIPE_PARITY_EN
        begin
            logic [$bits(dut.m_q)-1:0] tmp;
            tmp = dut.m_q;
            tmp[3] = ~tmp[3];
            force dut.m_q = tmp;
            cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
            release dut.m_q;
            checks++;
            if (parity_err !== 1'b1) begin
                errors++; $display("FAIL par_set got %0b want 1", parity_err);
            end
            cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
            checks++;
            if (parity_err !== 1'b1) begin
                errors++; $display("FAIL par_sticky got %0b want 1", parity_err);
            end
        end
`else
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (parity_err !== 1'b0) begin
            errors++; $display("FAIL par_off got %0b want 0", parity_err);
        end
        cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
`endif
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (parity_err !== 1'b0) begin
            errors++; $display("FAIL par_reset got %0b want 0", parity_err);
        end
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_parity();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
